outport_wh_arb: RTL and testbench

//  Wormhole output-port arbiter for one crossbar output in the 5-port router.

---
 rtl/noc_pkg.sv | 35 +++
 rtl/rr_pick.sv | 31 +++
 rtl/outport_wh_arb.sv | 80 ++++++++
 tb/tb_outport_wh_arb.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared router constants, arbiter state encoding and index helpers
package noc_pkg;

  localparam int NPORT = 5;
  localparam int OWNW  = 3;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  function automatic logic [NPORT-1:0] onehot(input logic [OWNW-1:0] idx);
    logic [NPORT-1:0] v;
    v = '0;
    for (int i = 0; i < NPORT; i++) begin
      if (idx == OWNW'(i)) v[i] = 1'b1;
    end
    return v;
  endfunction

  function automatic logic [OWNW-1:0] to_idx(input logic [NPORT-1:0] oh);
    logic [OWNW-1:0] idx;
    idx = '0;
    for (int i = 0; i < NPORT; i++) begin
      if (oh[i]) idx = OWNW'(i);
    end
    return idx;
  endfunction

  // Increment modulo NPORT, so indices never leave 0..NPORT-1.
  function automatic logic [OWNW-1:0] wrap_inc(input logic [OWNW-1:0] idx);
    return (idx == OWNW'(NPORT - 1)) ? '0 : idx + OWNW'(1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker starting the search at ptr
module rr_pick
  import noc_pkg::*;
(
  input  logic [NPORT-1:0] req,
  input  logic [OWNW-1:0]  ptr,
  output logic [NPORT-1:0] win_onehot,
  output logic [OWNW-1:0]  win_idx,
  output logic             any
);

  logic [OWNW-1:0] cand;
  logic            found;

  always_comb begin
    win_onehot = '0;
    cand       = ptr;
    found      = 1'b0;
    for (int k = 0; k < NPORT; k++) begin
      if (!found && req[cand]) begin
        win_onehot = onehot(cand);
        found      = 1'b1;
      end
      cand = wrap_inc(cand);
    end
  end

  assign win_idx = to_idx(win_onehot);
  assign any     = |req;

endmodule

// File: rtl/outport_wh_arb.sv
// rtl/outport_wh_arb.sv - wormhole output-port arbiter: round-robin pick, lock head to tail
module outport_wh_arb
  import noc_pkg::*;
(
  input  logic             clk,
  input  logic             rst_,
  input  logic [NPORT-1:0] req,
  input  logic [NPORT-1:0] tail,
  input  logic             credit_ok,
  output logic [NPORT-1:0] sel,
  output logic [NPORT-1:0] grt,
  output logic [OWNW-1:0]  owner,
  output logic             busy
);

  state_t          state_q, state_d;
  logic [OWNW-1:0] ptr_q, ptr_d;
  logic [OWNW-1:0] owner_q, owner_d;
  logic [NPORT-1:0] sel_q, sel_d;
  logic [NPORT-1:0] win_onehot;
  logic [OWNW-1:0]  win_idx;
  logic             any;
  logic             xfer;

  rr_pick u_pick (
    .req       (req),
    .ptr       (ptr_q),
    .win_onehot(win_onehot),
    .win_idx   (win_idx),
    .any       (any)
  );

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      sel_q   <= sel_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    sel_d   = sel_q;
    xfer    = 1'b0;
    case (state_q)
      IDLE: begin
        if (any && credit_ok) begin
          state_d = HOLD;
          owner_d = win_idx;
          sel_d   = win_onehot;
        end
      end
      HOLD: begin
        xfer = req[owner_q] && credit_ok;
        // Pointer moves only when the packet closes, so waiting inputs keep their turn.
        if (xfer && tail[owner_q]) begin
          state_d = IDLE;
          owner_d = '0;
          sel_d   = '0;
          ptr_d   = wrap_inc(owner_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign grt   = xfer ? onehot(owner_q) : '0;
  assign sel   = sel_q;
  assign owner = owner_q;
  assign busy  = (state_q == HOLD);

endmodule

// File: tb/tb_outport_wh_arb.sv
// tb/tb_outport_wh_arb.sv - self-checking bench: vector table, corner sequences, random vs model
module tb_outport_wh_arb;
  import noc_pkg::*;

  logic             clk = 1'b0;
  logic             rst_ = 1'b0;
  logic [NPORT-1:0] req = '0;
  logic [NPORT-1:0] tail = '0;
  logic             credit_ok = 1'b0;
  logic [NPORT-1:0] sel, grt;
  logic [OWNW-1:0]  owner;
  logic             busy;

  outport_wh_arb dut (
    .clk(clk), .rst_(rst_), .req(req), .tail(tail), .credit_ok(credit_ok),
    .sel(sel), .grt(grt), .owner(owner), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference model: locked flag, owner and pointer as plain integers.
  bit m_locked;
  int m_owner, m_ptr;
  // Observation history for the lock/fairness checks.
  bit   p_busy;
  int   p_owner;
  logic [NPORT-1:0] p_req;
  int   wait_cnt [NPORT];
  logic [NPORT-1:0] last_sel, last_grt;
  logic [OWNW-1:0]  last_owner;
  logic             last_busy;

  typedef struct {
    logic [NPORT-1:0] r, t;
    logic             c;
    logic [NPORT-1:0] e_sel, e_grt;
    logic             e_busy;
    logic [OWNW-1:0]  e_owner;
  } vec_t;
  vec_t tbl [15];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic int pick(input logic [NPORT-1:0] r, input int p);
    for (int k = 0; k < NPORT; k++)
      if (r[(p + k) % NPORT]) return (p + k) % NPORT;
    return -1;
  endfunction

  task automatic model_reset();
    m_locked = 0; m_owner = 0; m_ptr = 0;
    p_busy = 0; p_owner = 0; p_req = '0;
    for (int i = 0; i < NPORT; i++) wait_cnt[i] = 0;
  endtask

  // Drive one cycle: check at the falling edge, advance the model at the rising edge.
  task automatic cyc(input logic [NPORT-1:0] r, input logic [NPORT-1:0] t, input logic c,
                     input bit use_model);
    int w;
    req = r; tail = t; credit_ok = c;
    @(negedge clk);
    last_sel = sel; last_grt = grt; last_owner = owner; last_busy = busy;
    if (use_model) begin
      chk("sel", sel, m_locked ? (1 << m_owner) : 0);
      chk("owner", owner, m_locked ? m_owner : 0);
      chk("busy", busy, m_locked);
      chk("grt", grt, (m_locked && r[m_owner] && c) ? (1 << m_owner) : 0);
    end
    chk("sel_onehot0", $onehot0(sel), 1);
    chk("grt_onehot0", $onehot0(grt), 1);
    chk("grt_in_sel", int'((grt & ~sel) == '0), 1);
    chk("busy_eq_sel", busy, |sel);
    if (p_busy && busy) chk("owner_stable", owner, p_owner);
    if (!p_busy && busy) begin
      for (int i = 0; i < NPORT; i++) begin
        if (!p_req[i]) wait_cnt[i] = 0;
        else if (owner == OWNW'(i)) wait_cnt[i] = 0;
        else begin
          wait_cnt[i]++;
          if (wait_cnt[i] >= NPORT) chk("starve", wait_cnt[i], NPORT - 1);
        end
      end
    end
    p_busy = busy; p_owner = owner; p_req = r;
    @(posedge clk);
    if (!m_locked) begin
      w = pick(r, m_ptr);
      if (w >= 0 && c) begin m_locked = 1; m_owner = w; end
    end else if (r[m_owner] && c && t[m_owner]) begin
      m_locked = 0;
      m_ptr = (m_owner + 1) % NPORT;
    end
    #1;
  endtask

  task automatic do_reset();
    rst_ = 1'b0; req = '0; tail = '0; credit_ok = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_sel", sel, 0);
    chk("rst_grt", grt, 0);
    chk("rst_owner", owner, 0);
    chk("rst_busy", busy, 0);
    rst_ = 1'b1;
    model_reset();
  endtask

  initial begin
    tbl[0]  = '{5'b00100, 5'b00000, 1'b1, 5'b00000, 5'b00000, 1'b0, 3'd0};
    tbl[1]  = '{5'b00100, 5'b00000, 1'b1, 5'b00100, 5'b00100, 1'b1, 3'd2};
    tbl[2]  = '{5'b00100, 5'b00000, 1'b1, 5'b00100, 5'b00100, 1'b1, 3'd2};
    tbl[3]  = '{5'b00100, 5'b00100, 1'b1, 5'b00100, 5'b00100, 1'b1, 3'd2};
    tbl[4]  = '{5'b00000, 5'b00000, 1'b1, 5'b00000, 5'b00000, 1'b0, 3'd0};
    tbl[5]  = '{5'b11111, 5'b00000, 1'b0, 5'b00000, 5'b00000, 1'b0, 3'd0};
    tbl[6]  = '{5'b11111, 5'b11111, 1'b1, 5'b00000, 5'b00000, 1'b0, 3'd0};
    tbl[7]  = '{5'b11111, 5'b11111, 1'b1, 5'b01000, 5'b01000, 1'b1, 3'd3};
    tbl[8]  = '{5'b00000, 5'b11111, 1'b1, 5'b00000, 5'b00000, 1'b0, 3'd0};
    tbl[9]  = '{5'b00000, 5'b00000, 1'b1, 5'b00000, 5'b00000, 1'b0, 3'd0};
    tbl[10] = '{5'b10000, 5'b00000, 1'b1, 5'b00000, 5'b00000, 1'b0, 3'd0};
    tbl[11] = '{5'b10000, 5'b10000, 1'b1, 5'b10000, 5'b10000, 1'b1, 3'd4};
    tbl[12] = '{5'b00001, 5'b00001, 1'b1, 5'b00000, 5'b00000, 1'b0, 3'd0};
    tbl[13] = '{5'b00011, 5'b00001, 1'b1, 5'b00001, 5'b00001, 1'b1, 3'd0};
    tbl[14] = '{5'b00000, 5'b00000, 1'b1, 5'b00000, 5'b00000, 1'b0, 3'd0};

    do_reset();
    for (int i = 0; i < 15; i++) begin
      cyc(tbl[i].r, tbl[i].t, tbl[i].c, 0);
      chk($sformatf("tbl%0d_sel", i), last_sel, tbl[i].e_sel);
      chk($sformatf("tbl%0d_grt", i), last_grt, tbl[i].e_grt);
      chk($sformatf("tbl%0d_busy", i), last_busy, tbl[i].e_busy);
      chk($sformatf("tbl%0d_owner", i), last_owner, tbl[i].e_owner);
    end

    // All inputs with 1-flit packets: owners rotate with an idle cycle between.
    do_reset();
    for (int c = 0; c < 12; c++) begin
      cyc(5'b11111, 5'b11111, 1'b1, 1);
      chk($sformatf("rot%0d_grt", c), last_grt, (c % 2) ? (1 << ((c / 2) % NPORT)) : 0);
    end

    // Credit stall mid-packet with owner 1.
    do_reset();
    cyc(5'b00010, 5'b00000, 1'b1, 1);
    cyc(5'b00010, 5'b00000, 1'b1, 1);
    chk("stall_first_grt", last_grt, 5'b00010);
    for (int k = 0; k < 4; k++) begin
      cyc(5'b00010, 5'b00000, 1'b0, 1);
      chk("stall_grt", last_grt, 0);
      chk("stall_sel", last_sel, 5'b00010);
      chk("stall_busy", last_busy, 1);
    end
    cyc(5'b00010, 5'b00010, 1'b1, 1);
    chk("stall_resume_grt", last_grt, 5'b00010);
    cyc(5'b00000, 5'b00000, 1'b1, 1);
    chk("stall_idle", last_busy, 0);

    // Owner 3 bubbles while input 0 waits; then 4 wins over 0.
    cyc(5'b01000, 5'b00000, 1'b1, 1);
    cyc(5'b01000, 5'b00000, 1'b1, 1);
    chk("bub_owner", last_owner, 3);
    for (int k = 0; k < 2; k++) begin
      cyc(5'b00001, 5'b00000, 1'b1, 1);
      chk("bub_grt", last_grt, 0);
      chk("bub_sel", last_sel, 5'b01000);
    end
    cyc(5'b01001, 5'b01000, 1'b1, 1);
    chk("bub_tail_grt", last_grt, 5'b01000);
    cyc(5'b10001, 5'b00000, 1'b1, 1);
    cyc(5'b10001, 5'b00000, 1'b1, 1);
    chk("bub_next_sel", last_sel, 5'b10000);

    // Asynchronous reset mid-packet (owner 2).
    do_reset();
    cyc(5'b00100, 5'b00000, 1'b1, 1);
    cyc(5'b00100, 5'b00000, 1'b1, 1);
    chk("ar_owner_before", last_owner, 2);
    #2 rst_ = 1'b0;
    #1;
    chk("ar_sel", sel, 0);
    chk("ar_owner", owner, 0);
    chk("ar_busy", busy, 0);
    chk("ar_grt", grt, 0);
    @(posedge clk); #1;
    rst_ = 1'b1;
    model_reset();
    cyc(5'b11111, 5'b00000, 1'b1, 1);
    cyc(5'b11111, 5'b00000, 1'b1, 1);
    chk("ar_restart_sel", last_sel, 5'b00001);

    // Random traffic against the model.
    do_reset();
    for (int n = 0; n < 10000; n++) begin
      logic [NPORT-1:0] r, t;
      logic c;
      r = '0; t = '0;
      for (int i = 0; i < NPORT; i++) begin
        r[i] = ($urandom_range(0, 3) != 0);
        t[i] = ($urandom_range(0, 2) == 0);
      end
      c = ($urandom_range(0, 4) != 0);
      cyc(r, t, c, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
